// File: rtl/mult_pipe_pkg.sv
// mult_pipe_pkg
// Shared constants and helpers for the pipelined multiplier.
//   RND_TRUNC / RND_HALF_UP : legal values of the RND parameter.
//   guard_width()           : width of the full product plus one guard bit,
//                             wide enough that rounding never wraps.
package mult_pipe_pkg;

    localparam int RND_TRUNC   = 0;
    localparam int RND_HALF_UP = 1;

    function automatic int guard_width(input int a_width, input int b_width);
        return a_width + b_width + 1;
    endfunction

endpackage

// File: rtl/mult_pipe_fmt.sv
// mult_pipe_fmt
// Combinational multiply, scale, round and saturate.
// Ports:
//   A       in  A_width  operand A
//   B       in  B_width  operand B
//   TC      in  1        1 = both operands two's complement, 0 = unsigned
//   PRODUCT out P_width  scaled, rounded, saturated (or wrapped) product
//   OVF     out 1        the value was clamped; never set when SAT=0
module mult_pipe_fmt
    import mult_pipe_pkg::*;
#(
    parameter int A_width = 8,
    parameter int B_width = 8,
    parameter int P_width = 15,
    parameter int SHIFT   = 1,
    parameter int RND     = RND_TRUNC,
    parameter int SAT     = 1
) (
    input  logic [A_width-1:0] A,
    input  logic [B_width-1:0] B,
    input  logic               TC,
    output logic [P_width-1:0] PRODUCT,
    output logic               OVF
);

    // One bit wider than the exact product: an unsigned product plus the
    // rounding constant still fits, and a signed product keeps a sign bit.
    localparam int GW = guard_width(A_width, B_width);

    localparam logic [GW-1:0] ONE     = GW'(1);
    localparam logic [GW-1:0] RND_ADD = (RND == RND_HALF_UP && SHIFT > 0)
                                        ? ONE << (SHIFT > 0 ? SHIFT - 1 : 0)
                                        : '0;
    localparam logic [GW-1:0] U_MAX   = (ONE << P_width) - ONE;
    localparam logic [GW-1:0] S_MAX   = (ONE << (P_width - 1)) - ONE;
    localparam logic [GW-1:0] S_MIN   = ~S_MAX;   // -2^(P_width-1)

    logic [GW-1:0] a_ext;
    logic [GW-1:0] b_ext;
    logic [GW-1:0] full;
    logic [GW-1:0] rounded;
    logic [GW-1:0] scaled;

    // NOTE: every variable gets a default at the top of the block, so no
    // path through the if/else tree can leave one unassigned and infer a latch.
    always_comb begin
        // Sign extension is gated by TC; in unsigned mode the top bits are 0.
        a_ext   = {{(GW - A_width){A[A_width-1] & TC}}, A};
        b_ext   = {{(GW - B_width){B[B_width-1] & TC}}, B};
        full    = a_ext * b_ext;
        rounded = full + RND_ADD;
        scaled  = rounded >> SHIFT;
        PRODUCT = scaled[P_width-1:0];
        OVF     = 1'b0;

        // Kept as a separate branch: mixing signed and unsigned operands in a
        // ?: would silently turn the arithmetic shift into a logical one.
        if (TC) begin
            scaled  = $signed(rounded) >>> SHIFT;
            PRODUCT = scaled[P_width-1:0];
        end

        if (SAT != 0) begin
            if (TC) begin
                if ($signed(scaled) > $signed(S_MAX)) begin
                    PRODUCT = S_MAX[P_width-1:0];
                    OVF     = 1'b1;
                end else if ($signed(scaled) < $signed(S_MIN)) begin
                    PRODUCT = S_MIN[P_width-1:0];
                    OVF     = 1'b1;
                end
            end else if (scaled > U_MAX) begin
                PRODUCT = U_MAX[P_width-1:0];
                OVF     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_pipe.sv
// mult_pipe
// Pipelined multiplier with valid/ready handshake and whole-pipeline stall.
// The formatter sits combinationally ahead of stage 0; the DELAY stages each
// carry {valid, product, ovf} and advance together.
// Ports:
//   CLK       in  1        clock, rising edge
//   RST_N     in  1        asynchronous active-low reset
//   IN_VALID  in  1        A, B, TC valid this cycle
//   IN_READY  out 1        input accepted this cycle (combinational from OUT_READY)
//   A         in  A_width  operand A
//   B         in  B_width  operand B
//   TC        in  1        1 = two's complement operands, 0 = unsigned
//   OUT_VALID out 1        PRODUCT/OVF valid
//   OUT_READY in  1        consumer takes the output this cycle
//   PRODUCT   out P_width  result
//   OVF       out 1        saturation occurred for this result
module mult_pipe
    import mult_pipe_pkg::*;
#(
    parameter int DELAY   = 2,
    parameter int A_width = 8,
    parameter int B_width = 8,
    parameter int P_width = 15,
    parameter int SHIFT   = A_width + B_width - P_width,
    parameter int RND     = RND_TRUNC,
    parameter int SAT     = 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [A_width-1:0] A,
    input  logic [B_width-1:0] B,
    input  logic               TC,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [P_width-1:0] PRODUCT,
    output logic               OVF
);

    if (DELAY < 1) begin : g_bad_delay
        $error("mult_pipe: DELAY must be at least 1");
    end
    if (P_width < 1 || P_width > A_width + B_width) begin : g_bad_pwidth
        $error("mult_pipe: P_width must be in 1..A_width+B_width");
    end
    if (SHIFT < 0 || SHIFT > A_width + B_width - 1) begin : g_bad_shift
        $error("mult_pipe: SHIFT must be in 0..A_width+B_width-1");
    end
    if (RND != RND_TRUNC && RND != RND_HALF_UP) begin : g_bad_rnd
        $error("mult_pipe: RND must be 0 or 1");
    end

    typedef struct packed {
        logic               valid;
        logic [P_width-1:0] product;
        logic               ovf;
    } stage_t;

    logic [P_width-1:0] fmt_product;
    logic               fmt_ovf;
    logic               en;
    stage_t             stage_in;
    stage_t             stage_q [DELAY];

    mult_pipe_fmt #(
        .A_width (A_width),
        .B_width (B_width),
        .P_width (P_width),
        .SHIFT   (SHIFT),
        .RND     (RND),
        .SAT     (SAT)
    ) u_fmt (
        .A       (A),
        .B       (B),
        .TC      (TC),
        .PRODUCT (fmt_product),
        .OVF     (fmt_ovf)
    );

    // The pipeline moves whenever the output is taken or is a bubble, so
    // bubbles are squeezed out even while the consumer is not ready.
    // IN_READY is a combinational path from OUT_READY.
    assign en       = OUT_READY | ~OUT_VALID;
    assign IN_READY = en;

    always_comb begin
        stage_in.valid   = IN_VALID;
        stage_in.product = fmt_product;
        stage_in.ovf     = fmt_ovf;
    end

    // NOTE: the whole stage array is reset, not only the valid bits, because
    // PRODUCT and OVF must read 0 while in reset; the datapath is narrow.
    // NOTE: non-blocking assignments let every stage capture its predecessor's
    // pre-edge value, independent of statement order in the loop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DELAY; i++) begin
                stage_q[i] <= '0;
            end
        end else if (en) begin
            stage_q[0] <= stage_in;
            for (int i = 1; i < DELAY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign OUT_VALID = stage_q[DELAY-1].valid;
    assign PRODUCT   = stage_q[DELAY-1].product;
    assign OVF       = stage_q[DELAY-1].ovf;

endmodule

// File: tb/tb_mult_pipe.sv
// tb_mult_pipe
// Self-checking bench: one default-parameter instance driven with directed
// and random valid/ready traffic against a scoreboard, plus four 8-bit-output
// instances exercising saturation, wrap and rounding.
module tb_mult_pipe;

    typedef struct {
        logic [63:0] p;
        logic        o;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       tc;
        logic [7:0] sat_p;
        logic       sat_o;
        logic [7:0] wrap_p;
        logic [7:0] rnd_p;
        logic [7:0] trn_p;
    } row_t;

    logic clk;
    logic rst_n;

    // default instance (P_width=15, SHIFT=1, RND=0, SAT=1, DELAY=2)
    logic        in_valid, in_ready, out_valid, out_ready, tc, ovf;
    logic [7:0]  a, b;
    logic [14:0] product;

    // small instances share their inputs; consumer always ready
    logic       s_valid, s_tc, s_ready;
    logic [7:0] s_a, s_b;
    logic       sat_ir, sat_ov, sat_o, wrap_ir, wrap_ov, wrap_o;
    logic       rnd_ir, rnd_ov, rnd_o, trn_ir, trn_ov, trn_o;
    logic [7:0] sat_p, wrap_p, rnd_p, trn_p;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_out = 0;
    exp_t sb[$];
    bit   took;
    logic held_valid;
    logic [14:0] held_p;
    logic held_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mult_pipe u_dut (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
        .A(a), .B(b), .TC(tc), .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .PRODUCT(product), .OVF(ovf)
    );

    mult_pipe #(.P_width(8), .SHIFT(0), .SAT(1)) u_sat (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(s_valid), .IN_READY(sat_ir),
        .A(s_a), .B(s_b), .TC(s_tc), .OUT_VALID(sat_ov), .OUT_READY(s_ready),
        .PRODUCT(sat_p), .OVF(sat_o)
    );

    mult_pipe #(.P_width(8), .SHIFT(0), .SAT(0)) u_wrap (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(s_valid), .IN_READY(wrap_ir),
        .A(s_a), .B(s_b), .TC(s_tc), .OUT_VALID(wrap_ov), .OUT_READY(s_ready),
        .PRODUCT(wrap_p), .OVF(wrap_o)
    );

    mult_pipe #(.P_width(8), .SHIFT(8), .RND(1)) u_rnd (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(s_valid), .IN_READY(rnd_ir),
        .A(s_a), .B(s_b), .TC(s_tc), .OUT_VALID(rnd_ov), .OUT_READY(s_ready),
        .PRODUCT(rnd_p), .OVF(rnd_o)
    );

    mult_pipe #(.P_width(8), .SHIFT(8), .RND(0)) u_trn (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(s_valid), .IN_READY(trn_ir),
        .A(s_a), .B(s_b), .TC(s_tc), .OUT_VALID(trn_ov), .OUT_READY(s_ready),
        .PRODUCT(trn_p), .OVF(trn_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer product, optional +2^(sh-1), floor division
    // by 2^sh, then clamp (sat) or keep the low pw bits (wrap).
    function automatic void ref_model(input logic [7:0] av, input logic [7:0] bv,
                                      input logic tcv, input int pw, input int sh,
                                      input int rnd, input int sat,
                                      output logic [63:0] p, output logic o);
        longint x, y, full, d, q, lo, hi;
        if (tcv) begin
            x = longint'($signed(av));
            y = longint'($signed(bv));
            lo = -(longint'(1) << (pw - 1));
            hi = (longint'(1) << (pw - 1)) - 1;
        end else begin
            x = longint'(av);
            y = longint'(bv);
            lo = 0;
            hi = (longint'(1) << pw) - 1;
        end
        full = x * y;
        if (rnd == 1 && sh > 0) full = full + (longint'(1) << (sh - 1));
        d = longint'(1) << sh;
        q = full / d;
        if (full < 0 && (full % d) != 0) q = q - 1;
        o = 1'b0;
        if (sat != 0) begin
            if (q > hi) begin q = hi; o = 1'b1; end
            else if (q < lo) begin q = lo; o = 1'b1; end
        end
        p = 64'(q & ((longint'(1) << pw) - 1));
    endfunction

    // Scoreboard for the default instance: push on accept, pop on take,
    // and verify that a stalled output holds steady.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid) begin
                check("stall_hold_valid", out_valid, 1);
                check("stall_hold_product", product, held_p);
                check("stall_hold_ovf", ovf, held_o);
            end
            if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
            if (in_valid && in_ready) begin
                ref_model(a, b, tc, 15, 1, 0, 1, e.p, e.o);
                sb.push_back(e);
            end
            if (out_valid && out_ready) begin
                n_out++;
                check("sb_nonempty_on_output", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("stream_product", product, e.p);
                    check("stream_ovf", ovf, e.o);
                end
            end
            held_valid = out_valid && !out_ready;
            held_p     = product;
            held_o     = ovf;
        end
    end

    // Called at posedge+1. Presents fresh data only once the previous input
    // was taken (valid/ready rule), then samples at the negedge.
    task automatic cycle(input bit new_valid, input bit rdy, output logic ov, output logic ir);
        if (!in_valid || took) begin
            in_valid = new_valid;
            a  = 8'($urandom);
            b  = 8'($urandom);
            tc = 1'($urandom);
        end
        out_ready = rdy;
        @(negedge clk);
        took = in_valid && in_ready;
        ov   = out_valid;
        ir   = in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic ov, ir;
        for (int i = 0; i < 50 && sb.size() != 0; i++) cycle(0, 1, ov, ir);
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic small_txn(input logic [7:0] ta, input logic [7:0] tb, input logic ttc);
        @(posedge clk);
        #1;
        s_a = ta; s_b = tb; s_tc = ttc; s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        for (int i = 0; i < 8 && !sat_ov; i++) @(negedge clk);
        check("small_sat_valid", sat_ov, 1);
        check("small_wrap_valid", wrap_ov, 1);
        check("small_rnd_valid", rnd_ov, 1);
        check("small_trn_valid", trn_ov, 1);
    endtask

    task automatic check_small_model(input logic [7:0] ta, input logic [7:0] tb, input logic ttc);
        logic [63:0] p;
        logic        o;
        ref_model(ta, tb, ttc, 8, 0, 0, 1, p, o);
        check("sat_product", sat_p, p);  check("sat_ovf", sat_o, o);
        ref_model(ta, tb, ttc, 8, 0, 0, 0, p, o);
        check("wrap_product", wrap_p, p); check("wrap_ovf", wrap_o, o);
        ref_model(ta, tb, ttc, 8, 8, 1, 1, p, o);
        check("rnd_product", rnd_p, p);  check("rnd_ovf", rnd_o, o);
        ref_model(ta, tb, ttc, 8, 8, 0, 1, p, o);
        check("trn_product", trn_p, p);  check("trn_ovf", trn_o, o);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t        rows [3];
        logic [63:0] mp;
        logic        mo, ov, ir;
        int          acc, guard, out0;

        rows[0] = '{8'h80, 8'h80, 1'b1, 8'h7F, 1'b1, 8'h00, 8'h40, 8'h40};
        rows[1] = '{8'h80, 8'h01, 1'b0, 8'h80, 1'b0, 8'h80, 8'h01, 8'h00};
        rows[2] = '{8'hFF, 8'h80, 1'b1, 8'h7F, 1'b1, 8'h80, 8'h01, 8'h00};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; tc = 1'b0;
        s_valid = 1'b0; s_ready = 1'b1; s_a = '0; s_b = '0; s_tc = 1'b0;
        took = 1'b0;

        // Pin the reference model with hand-computed values.
        ref_model(8'hFF, 8'hFF, 1'b0, 15, 1, 0, 1, mp, mo);
        check("model_default_ffxff", mp, 64'h7F00);
        check("model_default_ffxff_ovf", mo, 0);
        for (int i = 0; i < 3; i++) begin
            ref_model(rows[i].a, rows[i].b, rows[i].tc, 8, 0, 0, 1, mp, mo);
            check("model_sat", mp, rows[i].sat_p);
            check("model_sat_ovf", mo, rows[i].sat_o);
            ref_model(rows[i].a, rows[i].b, rows[i].tc, 8, 0, 0, 0, mp, mo);
            check("model_wrap", mp, rows[i].wrap_p);
            ref_model(rows[i].a, rows[i].b, rows[i].tc, 8, 8, 1, 1, mp, mo);
            check("model_rnd", mp, rows[i].rnd_p);
            ref_model(rows[i].a, rows[i].b, rows[i].tc, 8, 8, 0, 1, mp, mo);
            check("model_trn", mp, rows[i].trn_p);
        end

        // Reset state.
        #3;
        check("reset_out_valid", out_valid, 0);
        check("reset_product", product, 0);
        check("reset_ovf", ovf, 0);
        check("reset_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency: 0xFF*0xFF unsigned appears exactly two cycles after accept.
        @(posedge clk);
        #1;
        a = 8'hFF; b = 8'hFF; tc = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("latency_not_yet", out_valid, 0);
        @(negedge clk);
        check("latency_valid", out_valid, 1);
        check("latency_product", product, 15'h7F00);
        check("latency_ovf", ovf, 0);
        @(posedge clk);
        #1;
        took = 1'b0;

        // Fill, stall for 10 cycles, then release for back-to-back outputs.
        for (int i = 0; i < 4; i++) cycle(1, 0, ov, ir);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 0, ov, ir);
            check("full_stall_in_ready", ir, 0);
            check("full_stall_out_valid", ov, 1);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, ov, ir);
            check("release_back_to_back", ov, 1);
        end
        cycle(0, 1, ov, ir);
        check("release_then_empty", ov, 0);
        check("release_sb_empty", sb.size(), 0);

        // Random streaming: 100 accepted inputs with 50% OUT_READY.
        out0  = n_out;
        acc   = 0;
        guard = 0;
        while (acc < 100 && guard < 3000) begin
            cycle(($urandom % 4) != 0, 1'($urandom), ov, ir);
            if (took) acc++;
            guard++;
        end
        check("stream_accepted", acc, 100);
        drain();
        check("stream_output_count", n_out - out0, 100);

        // Reset with two results in flight.
        for (int i = 0; i < 3; i++) cycle(1, 0, ov, ir);
        check("inflight_out_valid", out_valid, 1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("async_reset_out_valid", out_valid, 0);
        check("async_reset_product", product, 0);
        check("async_reset_ovf", ovf, 0);
        sb.delete();
        took = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out0 = n_out;
        cycle(1, 1, ov, ir);
        check("accept_after_reset", took, 1);
        drain();
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, ov, ir);
            check("no_stale_output", ov, 0);
        end
        check("post_reset_output_count", n_out - out0, 1);

        // Small instances: literal test-plan cases, then random operands.
        for (int i = 0; i < 3; i++) begin
            small_txn(rows[i].a, rows[i].b, rows[i].tc);
            check("lit_sat_product", sat_p, rows[i].sat_p);
            check("lit_sat_ovf", sat_o, rows[i].sat_o);
            check("lit_wrap_product", wrap_p, rows[i].wrap_p);
            check("lit_wrap_ovf", wrap_o, 0);
            check("lit_rnd_product", rnd_p, rows[i].rnd_p);
            check("lit_trn_product", trn_p, rows[i].trn_p);
            check_small_model(rows[i].a, rows[i].b, rows[i].tc);
        end
        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra, rb;
            logic       rt;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rt = 1'($urandom);
            small_txn(ra, rb, rt);
            check_small_model(ra, rb, rt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_pipe.md
# mult_pipe

Parametrised pipelined multiplier, the successor to the fixed-delay product core. It adds per-transaction signed/unsigned mode, a valid/ready handshake with full-pipeline stall, configurable output scaling with round-half-up, and saturation with an overflow flag in place of plain MSB slicing. It sits in the DSP datapath wherever a multiply feeds a narrower accumulator or quantiser.

## Interface
- DELAY, 2: pipeline depth and latency in cycles; legal values are 1 and above.
- A_width, 8: width of operand A.
- B_width, 8: width of operand B.
- P_width, 15: output width; must be ≤ A_width+B_width.
- SHIFT, A_width+B_width-P_width: number of LSBs dropped from the full product; range 0..A_width+B_width-1.
- RND, 0: 0 truncates (floor); 1 rounds half up.
- SAT, 1: 1 saturates to the P_width range; 0 wraps (keeps the low P_width bits).

Ports:
- CLK  in  1  clock; all logic is rising-edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  A, B and TC are valid this cycle.
- IN_READY  out  1  the pipeline accepts an input this cycle.
- A  in  A_width  operand A.
- B  in  B_width  operand B.
- TC  in  1  per-transaction mode: 0 = unsigned, 1 = both operands two's complement.
- OUT_VALID  out  1  PRODUCT is valid this cycle.
- OUT_READY  in  1  the consumer takes the output this cycle.
- PRODUCT  out  P_width  scaled, rounded and saturated product.
- OVF  out  1  saturation occurred for this PRODUCT; always 0 when SAT=0.

## Operation
- Full product: exact, A_width+B_width bits. It is signed when TC=1 and unsigned when TC=0. The result is correct for every operand including the most negative value.
- Rounding:
  - When RND=1 and SHIFT>0, add 2^(SHIFT-1) before the shift.
  - The addition uses one guard bit, so it never wraps.
  - The shift is arithmetic when TC=1 and logical when TC=0.
- Saturation range:
  - TC=1: [-2^(P_width-1), 2^(P_width-1)-1].
  - TC=0: [0, 2^P_width-1].
  - A value outside the range clamps to the nearest bound and sets OVF=1.
- Formatting is combinational ahead of stage 0. Every stage carries {valid, PRODUCT, OVF}.
- Stall rule:
  - en = OUT_READY | ~OUT_VALID.
  - All stages advance together when en=1.
  - IN_READY = en. This is a combinational path from OUT_READY and is documented as such.
- Input accept: the input is taken when IN_VALID & IN_READY. A stage whose valid bit is 0 is a bubble; bubbles are overwritten when the pipeline advances.
- No state machine is needed: the per-stage valid bits are the only control state.

## Timing
- Reset: all valid bits, OUT_VALID, PRODUCT and OVF go to 0 immediately on RST_N low. In-flight data is discarded with no output.
- Latency: an input accepted at edge N appears with OUT_VALID=1 after edge N+DELAY, provided there is no stall.
- Throughput: one result per cycle while OUT_READY=1.
- Stall hold: while OUT_VALID=1 and OUT_READY=0, PRODUCT, OVF and every stage are held, and IN_READY=0.
- Simultaneous pop and push: a full pipeline with OUT_READY=1 accepts a new input in the same cycle, so no bubble is inserted.
- Bubble squeeze: when OUT_VALID=0, the pipeline advances even if OUT_READY=0.
- Deassertion: RST_N deassertion is synchronised externally. The first accept is possible on the first edge after release.

## Structure
- Package mult_pipe_pkg holds:
  - RND_TRUNC=0 and RND_HALF_UP=1;
  - a function that computes the guard width, A_width+B_width+1.
- Sub-module mult_pipe_fmt: combinational multiply, round and saturate. Inputs are A, B and TC; outputs are PRODUCT and OVF. The top level is the valid/stall shift register around it.
- Parameter legality (P_width, SHIFT, DELAY) is checked with elaboration-time assertions.

## Test plan
- Defaults, TC=0, A=0xFF, B=0xFF -> PRODUCT=0x7F00, OVF=0, exactly 2 cycles after accept.
- P_width=8, SHIFT=0, SAT=1, TC=1, A=0x80, B=0x80 -> PRODUCT=0x7F, OVF=1. Same with SAT=0 -> PRODUCT=0x00, OVF=0.
- P_width=8, SHIFT=8, RND=1:
  - TC=0, A=0x80, B=0x01 -> PRODUCT=0x01.
  - TC=1, A=0xFF, B=0x80 -> PRODUCT=0x01.
  - Same cases with RND=0 -> 0x00.
- Streaming 100 random mixed-TC inputs with random OUT_READY (50% duty) -> outputs match a reference model in order, no loss or duplication, PRODUCT stable during every stall.
- Pipeline full with OUT_READY held 0 for 10 cycles -> IN_READY=0 throughout and outputs held. On release, back-to-back outputs with one per cycle.
- Assert RST_N low with 2 results in flight -> OUT_VALID=0, PRODUCT=0 and OVF=0 immediately. After release, no stale result ever appears.
